// File: rtl/wb_port_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_scheduler_if
// Brief    : Writeback, decode, long-unit and register-file signal bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_port_scheduler_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic                    regWriteW;
    logic [ADDR_W-1:0]       writeRegW;
    logic [DATA_W-1:0]       resultW;
    logic                    stallW;
    logic                    issueLongD;
    logic [ADDR_W-1:0]       issueRegD;
    logic [ADDR_W-1:0]       rsD;
    logic [ADDR_W-1:0]       rtD;
    logic                    stallD;
    logic                    longValid;
    logic [ADDR_W-1:0]       longReg;
    logic [DATA_W-1:0]       longData;
    logic                    longReady;
    logic                    rfWe;
    logic [ADDR_W-1:0]       rfAddr;
    logic [DATA_W-1:0]       rfData;
    logic [(1<<ADDR_W)-1:0]  pendingMask;

    modport master (
        output regWriteW, writeRegW, resultW,
        output issueLongD, issueRegD, rsD, rtD,
        output longValid, longReg, longData,
        input  stallW, stallD, longReady,
        input  rfWe, rfAddr, rfData, pendingMask
    );

    modport slave (
        input  regWriteW, writeRegW, resultW,
        input  issueLongD, issueRegD, rsD, rtD,
        input  longValid, longReg, longData,
        output stallW, stallD, longReady,
        output rfWe, rfAddr, rfData, pendingMask
    );
endinterface
`default_nettype wire

// File: rtl/wb_port_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_scheduler
// Brief    : Register-file write-port arbiter between the pipeline W stage and
//            a buffered long-latency unit, with a pending-write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module wb_port_scheduler #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int LQ_DEPTH   = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    wb_port_scheduler_if.slave bus
);
    localparam int c_PTR_W = $clog2(LQ_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_STV_W = $clog2(STARVE_MAX + 1);
    localparam int c_NREG  = 1 << ADDR_W;
    localparam logic [c_CNT_W-1:0] c_FULL   = c_CNT_W'(LQ_DEPTH);
    localparam logic [c_STV_W-1:0] c_STARVE = c_STV_W'(STARVE_MAX);

    logic [c_CNT_W-1:0] count_q, count_d;
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]  lq_reg_q  [LQ_DEPTH];
    logic [ADDR_W-1:0]  lq_reg_d  [LQ_DEPTH];
    logic [DATA_W-1:0]  lq_data_q [LQ_DEPTH];
    logic [DATA_W-1:0]  lq_data_d [LQ_DEPTH];
    logic [c_STV_W-1:0] starve_q, starve_d;
    logic               rf_we_q, rf_we_d;
    logic               rf_from_buf_q, rf_from_buf_d;
    logic [ADDR_W-1:0]  rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0]  rf_data_q, rf_data_d;
    logic [c_NREG-1:0]  pending_q, pending_d;

    logic w_empty, w_full, w_preq, w_push, w_pop, w_forced;
    logic w_grant_pipe, w_grant_buf, w_stall_d, w_issue_set, w_rf_clear;

    always_comb begin : p_ctrl
        w_empty      = (count_q == '0);
        w_full       = (count_q == c_FULL);
        w_preq       = bus.regWriteW && (bus.writeRegW != '0);
        w_forced     = !w_empty && w_preq && (starve_q == c_STARVE);
        w_grant_buf  = !w_empty && (!w_preq || w_forced);
        w_grant_pipe = w_preq && !w_forced;
        // Register-0 results are consumed from the long unit but never stored.
        w_push       = bus.longValid && !w_full && (bus.longReg != '0);
        w_pop        = w_grant_buf;
        w_stall_d    = pending_q[bus.rsD] | pending_q[bus.rtD]
                     | (bus.issueLongD & pending_q[bus.issueRegD]);
        w_issue_set  = bus.issueLongD && !w_stall_d && (bus.issueRegD != '0);
        w_rf_clear   = rf_we_q && rf_from_buf_q;
    end

    always_comb begin : p_next
        count_d   = count_q + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        wr_ptr_d  = w_push ? wr_ptr_q + c_PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = w_pop  ? rd_ptr_q + c_PTR_W'(1) : rd_ptr_q;
        lq_reg_d  = lq_reg_q;
        lq_data_d = lq_data_q;
        if (w_push) begin
            lq_reg_d[wr_ptr_q]  = bus.longReg;
            lq_data_d[wr_ptr_q] = bus.longData;
        end

        // A non-empty buffer that is not granted implies the pipeline won.
        if (w_empty || w_grant_buf) begin
            starve_d = '0;
        end else if (starve_q != c_STARVE) begin
            starve_d = starve_q + c_STV_W'(1);
        end else begin
            starve_d = starve_q;
        end

        rf_we_d       = w_grant_pipe || w_grant_buf;
        rf_from_buf_d = w_grant_buf;
        rf_addr_d     = '0;
        rf_data_d     = '0;
        if (w_grant_buf) begin
            rf_addr_d = lq_reg_q[rd_ptr_q];
            rf_data_d = lq_data_q[rd_ptr_q];
        end else if (w_grant_pipe) begin
            rf_addr_d = bus.writeRegW;
            rf_data_d = bus.resultW;
        end

        pending_d = pending_q;
        if (w_rf_clear) begin
            pending_d[rf_addr_q] = 1'b0;
        end
        if (w_issue_set) begin
            pending_d[bus.issueRegD] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_regs
        if (!rst_n) begin
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            starve_q      <= '0;
            rf_we_q       <= 1'b0;
            rf_from_buf_q <= 1'b0;
            rf_addr_q     <= '0;
            rf_data_q     <= '0;
            pending_q     <= '0;
            for (int i = 0; i < LQ_DEPTH; i++) begin
                lq_reg_q[i]  <= '0;
                lq_data_q[i] <= '0;
            end
        end else begin
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            starve_q      <= starve_d;
            rf_we_q       <= rf_we_d;
            rf_from_buf_q <= rf_from_buf_d;
            rf_addr_q     <= rf_addr_d;
            rf_data_q     <= rf_data_d;
            pending_q     <= pending_d;
            lq_reg_q      <= lq_reg_d;
            lq_data_q     <= lq_data_d;
        end
    end

    assign bus.stallW      = w_forced;
    assign bus.stallD      = w_stall_d;
    assign bus.longReady   = !w_full;
    assign bus.rfWe        = rf_we_q;
    assign bus.rfAddr      = rf_addr_q;
    assign bus.rfData      = rf_data_q;
    assign bus.pendingMask = pending_q;
endmodule
`default_nettype wire
